// File: rtl/jk_mod_updown_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with clipped load, debounced-edge step, and wrap/ovf flags.
// Optional COUNTER_BCD_EN adds a registered three-digit BCD view of q (bcd, bcd_sat).
module jk_mod_updown_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             step_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             load_err
`ifdef COUNTER_BCD_EN
    ,
    output logic [11:0]      bcd,
    output logic             bcd_sat
`endif
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic             s1, s2, s3;
    logic             step_pulse, do_step, over, force_en;
    logic             wrap_next, err_next;
    logic [WIDTH-1:0] target, tog, j, k, q_next;

    assign step_pulse = s2 & ~s3;
    assign do_step    = en & step_pulse & ~load;
    assign over       = (load_val > MAX_Q);
    assign tc         = up ? (q == MAX_Q) : (q == '0);

    // Each bit is a JK flop: force J/K to the target on load or wrap,
    // otherwise toggle along the carry (up) or borrow (down) chain.
    always_comb begin
        tog    = '0;
        tog[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tog[i] = tog[i-1] & (up ? q[i-1] : ~q[i-1]);
        end

        force_en = load | (do_step & tc);
        if (load) begin
            target = over ? MAX_Q : load_val;
        end else begin
            target = up ? '0 : MAX_Q;
        end

        if (force_en) begin
            j = target;
            k = ~target;
        end else if (do_step) begin
            j = tog;
            k = tog;
        end else begin
            j = '0;
            k = '0;
        end

        q_next    = (j & ~q) | (~k & q);
        wrap_next = do_step & tc;
        err_next  = load & over;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            q        <= '0;
            wrap     <= 1'b0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            s1       <= step_in;
            s2       <= s1;
            s3       <= s2;
            q        <= q_next;
            wrap     <= wrap_next;
            load_err <= err_next;
            ovf      <= wrap_next | (ovf & ~clr_ovf);
        end
    end

`ifdef COUNTER_BCD_EN
    logic [19:0] bcd_acc;
    logic        sat_next;

    // Shift-add-3 over five digits so any WIDTH up to 16 converts before saturation.
    always_comb begin
        bcd_acc = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            for (int d = 0; d < 5; d++) begin
                if (bcd_acc[4*d +: 4] >= 4'd5) begin
                    bcd_acc[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
                end
            end
            bcd_acc = {bcd_acc[18:0], q[i]};
        end
        sat_next = (17'(q) > 17'd999);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd     <= '0;
            bcd_sat <= 1'b0;
        end else begin
            bcd     <= sat_next ? 12'h999 : bcd_acc[11:0];
            bcd_sat <= sat_next;
        end
    end
`endif

endmodule

// File: tb/tb_jk_mod_updown_counter.sv
// Directed bench for jk_mod_updown_counter at WIDTH=4, MAX_VAL=9; BCD scenario when COUNTER_BCD_EN is defined.
module tb_jk_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, step_in, load, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap, ovf, load_err;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

`ifdef COUNTER_BCD_EN
    logic [11:0] bcd_a;
    logic        bcd_sat_a;
    logic        b_load;
    logic [9:0]  b_load_val;
    logic [9:0]  b_q;
    logic        b_tc, b_wrap, b_ovf, b_load_err;
    logic [11:0] b_bcd;
    logic        b_bcd_sat;
`endif

    jk_mod_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .step_in(step_in),
        .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q), .tc(tc), .wrap(wrap), .ovf(ovf), .load_err(load_err)
`ifdef COUNTER_BCD_EN
        , .bcd(bcd_a), .bcd_sat(bcd_sat_a)
`endif
    );

`ifdef COUNTER_BCD_EN
    jk_mod_updown_counter #(.WIDTH(10), .MAX_VAL(1023)) dut_bcd (
        .clk(clk), .rst(rst), .en(1'b1), .up(1'b1), .step_in(1'b0),
        .load(b_load), .load_val(b_load_val), .clr_ovf(1'b0),
        .q(b_q), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf), .load_err(b_load_err),
        .bcd(b_bcd), .bcd_sat(b_bcd_sat)
    );
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        load_val = v;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
    endtask

    // Raise step_in and return just after the edge where q takes the new value.
    task automatic do_step;
        step_in = 1'b1;
        tick(3);
        step_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; up = 1'b1; step_in = 1'b0;
        load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
`ifdef COUNTER_BCD_EN
        b_load = 1'b0; b_load_val = 10'd0;
`endif
        tick(2);
        total++; if ({q, wrap, ovf, load_err, tc} !== 8'b0000_0000) begin
            bad++; $display("FAIL reset_state: got q=%0d wrap=%b ovf=%b err=%b tc=%b, want all 0", q, wrap, ovf, load_err, tc);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_count_up_wrap;
        do_load(4'd8);
        tick(3);
        do_step;
        total++; if ({q, tc, wrap} !== {4'd9, 1'b1, 1'b0}) begin
            bad++; $display("FAIL up_to_max: got q=%0d tc=%b wrap=%b, want 9 1 0", q, tc, wrap);
        end
        tick(3);
        do_step;
        total++; if ({q, wrap, ovf} !== {4'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL up_wrap: got q=%0d wrap=%b ovf=%b, want 0 1 1", q, wrap, ovf);
        end
        tick(1);
        total++; if ({wrap, ovf} !== 2'b01) begin
            bad++; $display("FAIL wrap_one_cycle: got wrap=%b ovf=%b, want 0 1", wrap, ovf);
        end
        tick(2);
    endtask

    task automatic test_count_down_wrap;
        up = 1'b0;
        tick(1);
        do_step;
        total++; if ({q, wrap, tc} !== {4'd9, 1'b1, 1'b0}) begin
            bad++; $display("FAIL down_wrap: got q=%0d wrap=%b tc=%b, want 9 1 0", q, wrap, tc);
        end
        tick(3);
        do_step;
        total++; if ({q, wrap} !== {4'd8, 1'b0}) begin
            bad++; $display("FAIL down_step: got q=%0d wrap=%b, want 8 0", q, wrap);
        end
        tick(3);
        do_load(4'd9);
        up = 1'b1;
        #1;
        total++; if (tc !== 1'b1) begin
            bad++; $display("FAIL tc_comb_up: got %b, want 1", tc);
        end
        up = 1'b0;
        #1;
        total++; if (tc !== 1'b0) begin
            bad++; $display("FAIL tc_comb_down: got %b, want 0", tc);
        end
        up = 1'b1;
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        total++; if (ovf !== 1'b0) begin
            bad++; $display("FAIL clr_ovf: got %b, want 0", ovf);
        end
    endtask

    task automatic test_load_clip;
        do_load(4'd12);
        total++; if ({q, load_err} !== {4'd9, 1'b1}) begin
            bad++; $display("FAIL load_clip: got q=%0d err=%b, want 9 1", q, load_err);
        end
        tick(1);
        total++; if (load_err !== 1'b0) begin
            bad++; $display("FAIL load_err_pulse: got %b, want 0", load_err);
        end
        do_load(4'd5);
        total++; if ({q, load_err} !== {4'd5, 1'b0}) begin
            bad++; $display("FAIL load_in_range: got q=%0d err=%b, want 5 0", q, load_err);
        end
    endtask

    task automatic test_step_hold_and_enable;
        step_in = 1'b1;
        tick(2);
        total++; if (q !== 4'd5) begin
            bad++; $display("FAIL step_latency_early: got q=%0d, want 5", q);
        end
        tick(1);
        total++; if (q !== 4'd6) begin
            bad++; $display("FAIL step_latency: got q=%0d, want 6", q);
        end
        tick(47);
        step_in = 1'b0;
        total++; if (q !== 4'd6) begin
            bad++; $display("FAIL step_held: got q=%0d, want 6", q);
        end
        tick(3);
        en = 1'b0;
        do_step;
        tick(3);
        total++; if (q !== 4'd6) begin
            bad++; $display("FAIL en_low: got q=%0d, want 6", q);
        end
        en = 1'b1;
        tick(1);
        total++; if (q !== 4'd6) begin
            bad++; $display("FAIL en_not_queued: got q=%0d, want 6", q);
        end
    endtask

    task automatic test_coincidence;
        step_in = 1'b1;
        tick(2);
        load_val = 4'd2;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
        step_in  = 1'b0;
        tick(3);
        total++; if (q !== 4'd2) begin
            bad++; $display("FAIL load_beats_step: got q=%0d, want 2", q);
        end
        do_load(4'd9);
        tick(2);
        step_in = 1'b1;
        tick(2);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        step_in = 1'b0;
        total++; if ({q, wrap, ovf} !== {4'd0, 1'b1, 1'b1}) begin
            bad++; $display("FAIL wrap_vs_clr: got q=%0d wrap=%b ovf=%b, want 0 1 1", q, wrap, ovf);
        end
        tick(3);
        do_load(4'd7);
        #2;
        rst = 1'b1;
        #1;
        total++; if ({q, ovf} !== {4'd0, 1'b0}) begin
            bad++; $display("FAIL async_reset: got q=%0d ovf=%b, want 0 0", q, ovf);
        end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

`ifdef COUNTER_BCD_EN
    task automatic test_bcd;
        b_load_val = 10'd173;
        b_load     = 1'b1;
        tick(1);
        b_load     = 1'b0;
        tick(1);
        total++; if ({b_bcd, b_bcd_sat} !== {12'h173, 1'b0}) begin
            bad++; $display("FAIL bcd_173: got %h sat=%b, want 173 0", b_bcd, b_bcd_sat);
        end
        b_load_val = 10'd1000;
        b_load     = 1'b1;
        tick(1);
        b_load     = 1'b0;
        tick(1);
        total++; if ({b_bcd, b_bcd_sat} !== {12'h999, 1'b1}) begin
            bad++; $display("FAIL bcd_sat: got %h sat=%b, want 999 1", b_bcd, b_bcd_sat);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_count_up_wrap;
        test_count_down_wrap;
        test_load_clip;
        test_step_hold_and_enable;
        test_coincidence;
`ifdef COUNTER_BCD_EN
        test_bcd;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
